// File: rtl/route_lookup_stage.sv
// route_lookup_stage: next-hop lookup against a 1-cycle routing table port with a 3-entry in-order output buffer.
module route_lookup_stage #(
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH = 16,
  parameter logic [8:0] NOROUTE = 9'h1FF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  table_ready,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_dest,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  lut_en,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [8:0]            lut_nexthop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_dest,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [8:0]            out_nexthop,
  output logic                  out_noroute,
  output logic [15:0]           lookup_count,
  output logic [15:0]           noroute_count
);
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inf_dest;
  logic [TAG_WIDTH-1:0]  inf_tag;
  logic [ADDR_WIDTH-1:0] fifo_dest [3];
  logic [TAG_WIDTH-1:0]  fifo_tag [3];
  logic [8:0]            fifo_hop [3];
  logic [1:0]            wr_ptr, rd_ptr, fifo_count;
  logic [2:0]            occ;
  logic                  acc, deq, wr;
  // Counting the in-flight lookup in occupancy reserves its FIFO slot, so writes never need refusing.
  assign occ = {2'b0, inflight} + {1'b0, fifo_count};
  assign in_ready = table_ready & ~reset & (occ < 3'd3);
  assign acc = in_valid & in_ready;
  assign lut_en = acc;
  assign lut_addr = in_dest;
  assign wr = inflight;
  assign out_valid = fifo_count != 2'd0;
  assign deq = out_valid & out_ready;
  assign out_dest = fifo_dest[rd_ptr];
  assign out_tag = fifo_tag[rd_ptr];
  assign out_nexthop = fifo_hop[rd_ptr];
  assign out_noroute = out_valid & (out_nexthop == NOROUTE);
  always_ff @(posedge clock) begin
    if (acc) begin
      inf_dest <= in_dest;
      inf_tag <= in_tag;
    end
    if (wr) begin
      fifo_dest[wr_ptr] <= inf_dest;
      fifo_tag[wr_ptr] <= inf_tag;
      fifo_hop[wr_ptr] <= lut_nexthop;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      fifo_count <= 2'd0;
      lookup_count <= 16'd0;
      noroute_count <= 16'd0;
    end else begin
      inflight <= acc;
      fifo_count <= fifo_count + {1'b0, wr} - {1'b0, deq};
      if (wr) begin
        wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
        lookup_count <= lookup_count + {15'd0, lookup_count != 16'hFFFF};
        noroute_count <= noroute_count + {15'd0, lut_nexthop == NOROUTE && noroute_count != 16'hFFFF};
      end
      if (deq) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
    end
  end
endmodule

// File: doc/route_lookup_stage.md
# route_lookup_stage

Per-flit next-hop lookup stage that sits directly downstream of the dual-port routing table and consumes its port-A read data. It accepts destination/tag descriptors through a valid/ready handshake, drives the table's port-A address and enable, and aligns the 1-cycle registered read data with the descriptor. Results leave through an in-order 3-entry output buffer, so the stage absorbs downstream back-pressure without losing throughput. It also flags no-route results and keeps saturating lookup and no-route statistics.

## Interface
- ADDR_WIDTH, 8, width of the destination address and of the table port-A address.
- TAG_WIDTH, 16, width of the opaque descriptor tag carried alongside each lookup.
- NOROUTE, 9'h1FF, next-hop value meaning "no route".

- clock  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- table_ready  in  1  high once the routing table has finished loading its configuration.
- in_valid  in  1  input descriptor valid.
- in_ready  out  1  stage can accept a descriptor this cycle.
- in_dest  in  ADDR_WIDTH  destination address to look up.
- in_tag  in  TAG_WIDTH  descriptor tag; passed through unchanged.
- lut_en  out  1  table enable; equals the accept strobe.
- lut_addr  out  ADDR_WIDTH  table port-A address; equals in_dest.
- lut_nexthop  in  9  table port-A read data; valid the cycle after an accept.
- out_valid  out  1  output descriptor valid.
- out_ready  in  1  downstream accepts the output descriptor.
- out_dest, out_tag  out  ADDR_WIDTH, TAG_WIDTH  descriptor echoed on the output.
- out_nexthop  out  9  next hop returned by the lookup.
- out_noroute  out  1  high when out_nexthop == NOROUTE.
- lookup_count  out  16  saturating count of completed lookups.
- noroute_count  out  16  saturating count of no-route results.

## Operation
- Accept strobe: acc = in_valid & in_ready.
- in_ready = table_ready & (occ < 3).
  - occ = inflight + fifo_count.
  - in_ready is driven from registers plus table_ready only; it has no combinational path from out_ready.
- Cycle of acc:
  - lut_en = 1.
  - in_dest and in_tag are latched into the inflight register; inflight is set to 1.
- Cycle after acc:
  - lut_nexthop is written into the FIFO together with the latched dest and tag.
  - inflight clears unless a new acc occurs in the same cycle.
- FIFO:
  - 3 entries, in order.
  - Head drives all out_* signals; out_valid = (fifo_count != 0).
  - Dequeue on out_valid & out_ready.
  - A simultaneous write and dequeue leaves fifo_count unchanged.
  - A write is never refused: the occ rule guarantees space.
- No-route results are forwarded, not dropped; out_noroute is flagged on them.
- Counters:
  - lookup_count increments on each FIFO write.
  - noroute_count increments on each FIFO write with nexthop == NOROUTE.
  - Both hold at 16'hFFFF.
- table_ready falling mid-operation:
  - in_ready drops the same cycle.
  - The in-flight lookup and buffered entries still complete and drain normally.
- Reset clears inflight, fifo_count, the FIFO pointers and both counters.
  - An in-flight lookup is discarded.
  - The stored datapath contents are don't-care.

## Timing
- Reset values: in_ready 0 while reset is asserted, then table_ready & 1 after reset; out_valid 0; out_noroute 0; lut_en 0; lookup_count 0; noroute_count 0.
- Latency: acc in cycle t gives out_valid in cycle t+2, provided the FIFO was empty.
- Throughput: one descriptor per cycle sustained while out_ready = 1.
- Back-pressure with out_ready = 0: at most 3 descriptors are accepted, after which in_ready = 0.
  - in_ready returns the cycle after the first dequeue.
- Output handshake: out_* are stable while out_valid = 1 and out_ready = 0.
- lut_addr tracks in_dest combinationally; only cycles with lut_en = 1 are meaningful.

## Test plan
- table_ready = 0 with in_valid = 1 → in_ready = 0, lut_en = 0, out_valid never asserts. Raise table_ready → accepted next cycle.
- Single lookup: dest 8'h2A, tag 16'hBEEF, table returns 9'h005 → out_valid at t+2 with out_nexthop 9'h005, out_tag 16'hBEEF, out_noroute 0, lookup_count = 1.
- Streaming: 100 back-to-back descriptors with out_ready = 1 → 100 outputs on consecutive cycles, in order, tags match.
- Back-pressure: out_ready = 0, in_valid held high → exactly 3 accepts, then in_ready = 0. Release out_ready → outputs drain in order, with no loss or duplication.
- No-route: table returns 9'h1FF → out_noroute = 1 and noroute_count increments. Force both counters to 16'hFFFF → they hold at 16'hFFFF.
- Reset in the cycle after acc → no output appears, and out_valid = 0 plus both counters = 0 the cycle after reset.
